// File: rtl/blue_collision.sv
`default_nettype none
// ============================================================================
// Module   : blue_collision
// Purpose  : Once per frame, latches the blue player's top-left position and
//            probes the external tile map at eight points just outside the
//            player's bounding box (two per side). It then publishes a
//            registered 4-bit collision vector and a fire-hazard flag.
//
// Ports    : clk             - system clock
//            reset           - asynchronous, active-high reset
//            start           - frame tick; starts a sweep when idle
//            current_x       - player left edge, pixels (10 bits)
//            current_y       - player top edge, pixels (9 bits)
//            tile_addr       - map ROM address, row*MAP_COLS + col (11 bits)
//            tile_data       - ROM data, one cycle after tile_addr
//                              (00 empty, 01 wall, 10 water, 11 fire)
//            busy            - high from the cycle after start until done
//            done            - one-cycle pulse when results update
//            collision_state - [0] ground, [1] ceiling, [2] right, [3] left
//            hazard          - fire tile under the player's feet
//
// Revision : 1.0 - initial release
// ============================================================================
module blue_collision #(
  parameter int PLAYER_W = 14,
  parameter int PLAYER_H = 20,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int MAP_COLS = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  current_x,
  input  logic [8:0]  current_y,
  output logic [10:0] tile_addr,
  input  logic [1:0]  tile_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  collision_state,
  output logic        hazard
);

  // 11-bit copies of the geometry so all coordinate math stays 11 bits wide.
  localparam logic [10:0] C_W    = 11'(PLAYER_W);
  localparam logic [10:0] C_H    = 11'(PLAYER_H);
  localparam logic [10:0] C_SW   = 11'(SCREEN_W);
  localparam logic [10:0] C_SH   = 11'(SCREEN_H);
  localparam logic [10:0] C_COLS = 11'(MAP_COLS);

  localparam logic [1:0] C_TILE_WALL = 2'b01;
  localparam logic [1:0] C_TILE_FIRE = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Probe k belongs to side k[2:1]: 0 ground, 1 ceiling, 2 right, 3 left.
  // A side whose probes would leave the playfield is forced solid.
  function automatic logic probe_oob(input logic [2:0]  k,
                                     input logic [10:0] px,
                                     input logic [10:0] py);
    logic oob;
    case (k[2:1])
      2'd0:    oob = (py + C_H) >= C_SH;
      2'd1:    oob = (py == 11'd0);
      2'd2:    oob = (px + C_W) >= C_SW;
      default: oob = (px == 11'd0);
    endcase
    return oob;
  endfunction

  // Map address for probe k; out-of-bounds probes drive address 0.
  function automatic logic [10:0] probe_addr(input logic [2:0]  k,
                                             input logic [10:0] px,
                                             input logic [10:0] py);
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] col;
    logic [10:0] row;
    case (k)
      3'd0:    begin x = px;              y = py + C_H;          end
      3'd1:    begin x = px + C_W - 11'd1; y = py + C_H;          end
      3'd2:    begin x = px;              y = py - 11'd1;        end
      3'd3:    begin x = px + C_W - 11'd1; y = py - 11'd1;        end
      3'd4:    begin x = px + C_W;        y = py;                end
      3'd5:    begin x = px + C_W;        y = py + C_H - 11'd1;  end
      3'd6:    begin x = px - 11'd1;      y = py;                end
      default: begin x = px - 11'd1;      y = py + C_H - 11'd1;  end
    endcase
    col = x >> 4;
    row = y >> 4;
    if (probe_oob(k, px, py)) begin
      return 11'd0;
    end
    return (row * C_COLS) + col;
  endfunction

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [10:0] px_q;
  logic [10:0] py_q;
  logic [3:0]  acc_q;
  logic        haz_q;
  logic [10:0] tile_addr_q;
  logic        busy_q;
  logic        done_q;
  logic [3:0]  coll_q;
  logic        hazard_q;

  logic [3:0]  acc_d;
  logic        haz_d;
  logic [2:0]  cap_k;
  logic        cap_en;
  logic        cap_oob;
  logic [10:0] start_px;
  logic [10:0] start_py;
  logic [10:0] start_addr;
  logic [10:0] next_addr;

  // tile_data present in the current cycle belongs to the probe issued one
  // cycle earlier: k-1 while probing, probe 7 in the drain cycle.
  always_comb begin
    cap_k   = (state_q == S_DRAIN) ? 3'd7 : (cnt_q - 3'd1);
    cap_en  = (state_q == S_DRAIN) || ((state_q == S_PROBE) && (cnt_q != 3'd0));
    cap_oob = probe_oob(cap_k, px_q, py_q);
    acc_d   = acc_q;
    haz_d   = haz_q;
    if (cap_en) begin
      if (cap_oob || (tile_data == C_TILE_WALL)) begin
        acc_d[cap_k[2:1]] = 1'b1;
      end
      // Only the two feet probes can report fire, and only when on the map.
      if ((cap_k[2:1] == 2'd0) && !cap_oob && (tile_data == C_TILE_FIRE)) begin
        haz_d = 1'b1;
      end
    end
    // Probe 0 is addressed straight from the inputs so it goes out in the
    // first cycle after start, before the latched position is available.
    start_px   = {1'b0, current_x};
    start_py   = {2'b00, current_y};
    start_addr = probe_addr(3'd0, start_px, start_py);
    next_addr  = probe_addr(cnt_q + 3'd1, px_q, py_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      px_q        <= 11'd0;
      py_q        <= 11'd0;
      acc_q       <= 4'd0;
      haz_q       <= 1'b0;
      tile_addr_q <= 11'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      coll_q      <= 4'd0;
      hazard_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            px_q        <= start_px;
            py_q        <= start_py;
            tile_addr_q <= start_addr;
            cnt_q       <= 3'd0;
            acc_q       <= 4'd0;
            haz_q       <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_PROBE;
          end
        end
        S_PROBE: begin
          acc_q <= acc_d;
          haz_q <= haz_d;
          if (cnt_q == 3'd7) begin
            tile_addr_q <= 11'd0;
            cnt_q       <= 3'd0;
            state_q     <= S_DRAIN;
          end else begin
            tile_addr_q <= next_addr;
            cnt_q       <= cnt_q + 3'd1;
          end
        end
        S_DRAIN: begin
          // Publish all four sides at once so no partial sweep is visible.
          acc_q    <= acc_d;
          haz_q    <= haz_d;
          coll_q   <= acc_d;
          hazard_q <= haz_d;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tile_addr       = tile_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign collision_state = coll_q;
  assign hazard          = hazard_q;

endmodule
`default_nettype wire

// File: tb/tb_blue_collision.sv
`default_nettype none
// ============================================================================
// Module   : tb_blue_collision
// Purpose  : Directed bench for blue_collision with a synchronous map ROM
//            model and a scoreboard of expected sweep results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blue_collision;

  localparam int PW   = 14;
  localparam int PH   = 20;
  localparam int SW   = 640;
  localparam int SH   = 480;
  localparam int COLS = 40;

  logic        clk;
  logic        reset;
  logic        start;
  logic [9:0]  current_x;
  logic [8:0]  current_y;
  logic [10:0] tile_addr;
  logic [1:0]  tile_data;
  logic        busy;
  logic        done;
  logic [3:0]  collision_state;
  logic        hazard;

  blue_collision #(
    .PLAYER_W(PW), .PLAYER_H(PH), .SCREEN_W(SW), .SCREEN_H(SH), .MAP_COLS(COLS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .current_x(current_x),
    .current_y(current_y),
    .tile_addr(tile_addr),
    .tile_data(tile_data),
    .busy(busy),
    .done(done),
    .collision_state(collision_state),
    .hazard(hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map ROM with a one-cycle synchronous read.
  logic [1:0] map_mem [0:2047];
  initial tile_data = 2'b00;
  always @(posedge clk) tile_data <= map_mem[tile_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] coll;
    logic       haz;
    int         cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;

  logic [3:0]  last_coll = 4'd0;
  logic        last_haz  = 1'b0;
  logic [10:0] exp_addr [8];
  logic [3:0]  exp_coll;
  logic        exp_haz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic fill_map(input logic [1:0] v);
    for (int i = 0; i < 2048; i++) map_mem[i] = v;
  endtask

  // Reference model of one sweep, straight from the probe table.
  function automatic void model(input int x, input int y);
    int xs [8];
    int ys [8];
    bit bad;
    int a;
    logic [1:0] t;
    xs = '{x, x+PW-1, x, x+PW-1, x+PW, x+PW, x-1, x-1};
    ys = '{y+PH, y+PH, y-1, y-1, y, y+PH-1, y, y+PH-1};
    exp_coll = 4'd0;
    exp_haz  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      case (k / 2)
        0:       bad = (y + PH >= SH);
        1:       bad = (y == 0);
        2:       bad = (x + PW >= SW);
        default: bad = (x == 0);
      endcase
      a = bad ? 0 : (ys[k] / 16) * COLS + (xs[k] / 16);
      exp_addr[k] = 11'(a);
      t = bad ? 2'b01 : map_mem[a];
      if (t == 2'b01) exp_coll[k/2] = 1'b1;
      if (k < 2 && !bad && t == 2'b11) exp_haz = 1'b1;
    end
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_cycle", cyc, mon_e.cyc);
        check("collision_state", {28'd0, collision_state}, {28'd0, mon_e.coll});
        check("hazard", {31'd0, hazard}, {31'd0, mon_e.haz});
        last_coll = mon_e.coll;
        last_haz  = mon_e.haz;
      end
    end
  end

  task automatic sweep(input int x, input int y, input bit dbl);
    exp_t e;
    model(x, y);
    @(negedge clk);
    current_x = 10'(x);
    current_y = 9'(y);
    start     = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    e.coll = exp_coll;
    e.haz  = exp_haz;
    e.cyc  = cyc + 9;
    sb.push_back(e);
    // Inputs moving mid-sweep must not disturb the result.
    current_x = 10'($urandom);
    current_y = 9'($urandom);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("addr_slot%0d", k), {21'd0, tile_addr}, {21'd0, exp_addr[k]});
      check("hold_coll", {28'd0, collision_state}, {28'd0, last_coll});
      check("hold_haz", {31'd0, hazard}, {31'd0, last_haz});
      if (dbl && k == 2) start = 1'b1;
      if (dbl && k == 3) start = 1'b0;
    end
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    if (dbl) repeat (15) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_coll"}, {28'd0, collision_state}, 32'd0);
    check({tag, "_haz"}, {31'd0, hazard}, 32'd0);
    check({tag, "_addr"}, {21'd0, tile_addr}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    current_x = 10'd0;
    current_y = 9'd0;
    fill_map(2'b00);
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Wall tiles at row 13, cols 6..7.
    map_mem[13*COLS+6] = 2'b01;
    map_mem[13*COLS+7] = 2'b01;
    sweep(100, 200, 1'b0);

    // Same tiles as fire: non-solid, hazard under feet.
    map_mem[13*COLS+6] = 2'b11;
    map_mem[13*COLS+7] = 2'b11;
    sweep(100, 200, 1'b0);

    // Top-left corner: ceiling and left forced, their slots address 0.
    fill_map(2'b00);
    sweep(0, 0, 1'b0);

    // Bottom-right corner: ground and right forced.
    sweep(626, 460, 1'b0);

    // Feet off the bottom over fire: forced ground, no hazard.
    fill_map(2'b11);
    sweep(300, 460, 1'b0);

    // Walls everywhere, with a second start during the sweep.
    fill_map(2'b01);
    sweep(200, 100, 1'b1);

    // Reset in the middle of a sweep aborts it.
    fill_map(2'b10);
    @(negedge clk);
    current_x = 10'd100;
    current_y = 9'd200;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    last_coll = 4'd0;
    last_haz  = 1'b0;
    check_reset_vals("abort");
    repeat (15) @(negedge clk);

    // Normal sweep after the abort.
    fill_map(2'b00);
    map_mem[12*COLS+7] = 2'b01;
    map_mem[13*COLS+6] = 2'b11;
    sweep(100, 200, 1'b0);

    check("sb_final", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
